// File: rtl/layerio_wr_tracker_if.sv
// Write-tracker bus: layer config handshake, write strobe and the steering/address results.
// Under LAYERIO_PINGPONG_EN, flat_addr carries an extra MSB and bank_sel is present.
interface layerio_wr_tracker_if #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 1024,
  parameter int SIZE_W   = 16,
  parameter int W_W      = 10
);
  localparam int CW = $clog2(CHANNELS);
  localparam int BW = $clog2(DEPTH/CHANNELS);
`ifdef LAYERIO_PINGPONG_EN
  localparam int FW = $clog2(DEPTH) + 1;
`else
  localparam int FW = $clog2(DEPTH);
`endif

  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [SIZE_W-1:0]            size;
  logic [W_W-1:0]               size_w;
  logic [W_W-1:0]               stride_w;
  logic [SIZE_W-1:0]            wr_offset;
  logic                         islastlayer;
  logic                         en;
  logic [CW-1:0]                chansel;
  logic [CHANNELS-1:0][BW-1:0]  chan_addr;
  logic [FW-1:0]                flat_addr;
  logic                         writing_layer_next;
  logic                         wrote_layer;
  logic                         cfg_err;
`ifdef LAYERIO_PINGPONG_EN
  logic                         bank_sel;

  modport master (output cfg_valid, size, size_w, stride_w, wr_offset, islastlayer, en,
                  input  cfg_ready, chansel, chan_addr, flat_addr, writing_layer_next,
                         wrote_layer, cfg_err, bank_sel);
  modport slave  (input  cfg_valid, size, size_w, stride_w, wr_offset, islastlayer, en,
                  output cfg_ready, chansel, chan_addr, flat_addr, writing_layer_next,
                         wrote_layer, cfg_err, bank_sel);
`else
  modport master (output cfg_valid, size, size_w, stride_w, wr_offset, islastlayer, en,
                  input  cfg_ready, chansel, chan_addr, flat_addr, writing_layer_next,
                         wrote_layer, cfg_err);
  modport slave  (input  cfg_valid, size, size_w, stride_w, wr_offset, islastlayer, en,
                  output cfg_ready, chansel, chan_addr, flat_addr, writing_layer_next,
                         wrote_layer, cfg_err);
`endif
endinterface

// File: rtl/layerio_wr_tracker.sv
// Layer write tracker: steers writes across CHANNELS banks, generates remapped bank/flat addresses
// and pulses wrote_layer at layer end. Optional double-buffering via LAYERIO_PINGPONG_EN.

// Per-bank address counter with offset remap.
module layerio_wr_tracker_lane #(
  parameter int BW     = 8,
  parameter int CW     = 2,
  parameter int SIZE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  input  logic [SIZE_W-1:0] off,
  output logic [BW-1:0]     addr_map
);
  logic [BW-1:0] addr_q;

  always_ff @(posedge clk)
    if (reset || clr) addr_q <= '0;
    else if (inc)     addr_q <= addr_q + 1'b1;

  always_comb begin
    addr_map = addr_q;
    if (off == SIZE_W'(1))      addr_map = ~addr_q;
    else if (off != '0)         addr_map = addr_q - BW'(off >> CW);
  end
endmodule

module layerio_wr_tracker #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 1024,
  parameter int SIZE_W   = 16,
  parameter int W_W      = 10,
  parameter int LATENCY  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  layerio_wr_tracker_if.slave  io
);
  localparam int CW = $clog2(CHANNELS);
  localparam int BW = $clog2(DEPTH/CHANNELS);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  typedef struct packed {
    logic [CW-1:0]               chansel;
    logic [CHANNELS-1:0][BW-1:0] chan;
    logic [AW-1:0]               flat;
  } out_t;

  state_t            state;
  logic [SIZE_W-1:0] size_m1, off_q, count;
  logic [W_W-1:0]    size_w_m1, stride_m1, w, w_mod;
  logic [CW-1:0]     chansel_q;
  logic [AW-1:0]     flat_q;
  logic              cfg_ready_q, wrote_q, cfg_err_q;
  logic              cfg_ok, wr, wr_last;
  out_t              raw, out;

  assign cfg_ok  = (io.size != '0) && (io.size_w != '0) && (io.stride_w != '0);
  assign wr      = (state == WRITE) && io.en;
  assign wr_last = wr && (count == size_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      size_m1     <= '0;
      size_w_m1   <= '0;
      stride_m1   <= '0;
      off_q       <= '0;
      count       <= '0;
      w           <= '0;
      w_mod       <= '0;
      chansel_q   <= '0;
      flat_q      <= '0;
      cfg_ready_q <= 1'b1;
      wrote_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      wrote_q <= 1'b0;
      case (state)
        IDLE: if (io.cfg_valid) begin
          if (cfg_ok) begin
            size_m1     <= io.size - 1'b1;
            size_w_m1   <= io.size_w - 1'b1;
            stride_m1   <= io.stride_w - 1'b1;
            off_q       <= io.wr_offset;
            cfg_ready_q <= 1'b0;
            state       <= WRITE;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
        WRITE: if (wr_last) begin
          count     <= '0;
          w         <= '0;
          w_mod     <= '0;
          chansel_q <= '0;
          flat_q    <= '0;
          wrote_q   <= !io.islastlayer;
          state     <= DONE;
        end else if (wr) begin
          count  <= count + 1'b1;
          flat_q <= flat_q + 1'b1;
          // Row wrap restarts the bank walk and overrides any bank advance.
          if (w == size_w_m1) begin
            w         <= '0;
            w_mod     <= '0;
            chansel_q <= '0;
          end else begin
            w <= w + 1'b1;
            if (w_mod == stride_m1) begin
              w_mod     <= '0;
              chansel_q <= chansel_q + 1'b1;
            end else begin
              w_mod <= w_mod + 1'b1;
            end
          end
        end
        default: begin
          cfg_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    layerio_wr_tracker_lane #(.BW(BW), .CW(CW), .SIZE_W(SIZE_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .inc      (wr && (chansel_q == CW'(i))),
      .clr      (wr_last),
      .off      (off_q),
      .addr_map (raw.chan[i])
    );
  end

  assign raw.chansel = chansel_q;
  always_comb begin
    raw.flat = flat_q;
    if (off_q == SIZE_W'(1)) raw.flat = ~flat_q;
    else if (off_q != '0)    raw.flat = flat_q - AW'(off_q);
  end

  if (LATENCY == 0) begin : g_nopipe
    assign out = raw;
  end else begin : g_pipe
    out_t [LATENCY-1:0] stg;
    always_ff @(posedge clk)
      if (reset) stg <= '0;
      else       stg <= {stg, raw} >> $bits(out_t) * 0;
    assign out = stg[LATENCY-1];
  end

  assign io.cfg_ready          = cfg_ready_q;
  assign io.chansel            = out.chansel;
  assign io.chan_addr          = out.chan;
  assign io.writing_layer_next = wr_last;
  assign io.wrote_layer        = wrote_q;
  assign io.cfg_err            = cfg_err_q;

`ifdef LAYERIO_PINGPONG_EN
  logic bank_sel_q;
  always_ff @(posedge clk)
    if (reset)        bank_sel_q <= 1'b0;
    else if (wrote_q) bank_sel_q <= !bank_sel_q;
  assign io.bank_sel  = bank_sel_q;
  assign io.flat_addr = {bank_sel_q, out.flat};
`else
  assign io.flat_addr = out.flat;
`endif
endmodule

// File: tb/tb_layerio_wr_tracker.sv
// Randomized + directed bench for layerio_wr_tracker against an index-based reference model.
module tb_layerio_wr_tracker;
  localparam int CH = 4, DEPTH = 1024, SIZE_W = 16, W_W = 10, LAT = 1;
  localparam int BD = DEPTH / CH, BW = 8;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  layerio_wr_tracker_if #(.CHANNELS(CH), .DEPTH(DEPTH), .SIZE_W(SIZE_W), .W_W(W_W)) io();
  layerio_wr_tracker #(.CHANNELS(CH), .DEPTH(DEPTH), .SIZE_W(SIZE_W), .W_W(W_W), .LATENCY(LAT))
    dut (.clk(clk), .reset(reset), .io(io));

  int ntests = 0, nfail = 0;
  int m_off = 0, m_err = 0;
  int bank_cnt[CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rf(input int a, input int off);
    if (off == 0) return a;
    if (off == 1) return DEPTH - 1 - a;
    return ((DEPTH - off + a) % DEPTH + DEPTH) % DEPTH;
  endfunction

  function automatic int rb(input int a, input int off);
    if (off == 0) return a;
    if (off == 1) return BD - 1 - a;
    return ((BD - off / CH + a) % BD + BD) % BD;
  endfunction

  function automatic logic [63:0] chan_vec(input int off);
    logic [63:0] v = '0;
    for (int c = 0; c < CH; c++) v[c*BW +: BW] = 8'(rb(bank_cnt[c], off));
    return v;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    for (int c = 0; c < CH; c++) bank_cnt[c] = 0;
    chk({tag, "_chansel"}, 64'(io.chansel), 64'd0);
    chk({tag, "_chan"}, 64'(io.chan_addr), chan_vec(m_off));
    chk({tag, "_flat"}, 64'(io.flat_addr), 64'(rf(0, m_off)));
    chk({tag, "_rdy"}, 64'(io.cfg_ready), 64'd1);
    chk({tag, "_err"}, 64'(io.cfg_err), 64'(m_err));
  endtask

  // Runs one layer; stops early (leaving the DUT mid-layer) after lim writes.
  task automatic layer(input int sz, sw, st, off, last, pen, lim);
    int k = 0;
    logic e;
    @(negedge clk);
    chk("cfg_ready_idle", 64'(io.cfg_ready), 64'd1);
    io.cfg_valid = 1'b1; io.size = 16'(sz); io.size_w = 10'(sw); io.stride_w = 10'(st);
    io.wr_offset = 16'(off); io.islastlayer = last[0];
    @(negedge clk);
    io.cfg_valid = 1'b0;
    chk("cfg_ready_busy", 64'(io.cfg_ready), 64'd0);
    m_off = off;
    for (int c = 0; c < CH; c++) bank_cnt[c] = 0;
    while (k < sz && k < lim) begin
      int cs, fl;
      logic [63:0] cv;
      e = ($urandom % 100) < pen;
      io.en = e;
      #1;
      chk("wln", 64'(io.writing_layer_next), 64'(e && k == sz - 1));
      cs = ((k % sw) / st) % CH;
      cv = chan_vec(off);
      fl = rf(k % DEPTH, off);
      if (e) begin
        bank_cnt[cs] = (bank_cnt[cs] + 1) % BD;
        k++;
      end
      @(posedge clk); #1;
      chk("chansel", 64'(io.chansel), 64'(cs));
      chk("chan_addr", 64'(io.chan_addr), cv);
      chk("flat_addr", 64'(io.flat_addr), 64'(fl));
      if (k < sz) chk("no_pulse", 64'(io.wrote_layer), 64'd0);
      else        chk("wrote_layer", 64'(io.wrote_layer), 64'(!last));
      @(negedge clk);
    end
    io.en = 1'b1;
    if (k == sz) begin
      @(posedge clk); #1;
      chk("pulse_end", 64'(io.wrote_layer), 64'd0);
      chk_idle_outputs("done");
      @(posedge clk); #1;
      chk("idle_en_dropped", 64'(io.flat_addr), 64'(rf(0, m_off)));
      @(negedge clk);
    end
    io.en = 1'b0;
  endtask

  initial begin
    io.cfg_valid = 1'b0; io.en = 1'b0; io.size = '0; io.size_w = '0; io.stride_w = '0;
    io.wr_offset = '0; io.islastlayer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrote", 64'(io.wrote_layer), 64'd0);
    chk_idle_outputs("rst");
    @(negedge clk); reset = 1'b0;

    layer(8, 8, 2, 0, 0, 100, 1 << 30);
    layer(12, 6, 4, 0, 0, 100, 1 << 30);
    layer(3, 3, 3, 1, 0, 100, 1 << 30);
    layer(4, 4, 4, 8, 0, 100, 1 << 30);
    layer(1, 1, 1, 0, 1, 100, 1 << 30);

    layer(8, 8, 2, 5, 0, 100, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    m_off = 0; m_err = 0;
    chk("midrst_wrote", 64'(io.wrote_layer), 64'd0);
    chk_idle_outputs("midrst");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_nopulse", 64'(io.wrote_layer), 64'd0);
    @(negedge clk);
    io.cfg_valid = 1'b1; io.size = '0; io.size_w = 10'd4; io.stride_w = 10'd2;
    @(negedge clk);
    io.cfg_valid = 1'b0; m_err = 1;
    chk_idle_outputs("cfgerr");
    @(negedge clk);
    chk("cfgerr_stay", 64'(io.cfg_ready), 64'd1);

    layer(1100, 1023, 1023, 3, 0, 100, 1 << 30);
    for (int n = 0; n < 20; n++) begin
      int off, kind;
      kind = int'($urandom % 4);
      off = (kind == 0) ? 0 : (kind == 1) ? 1 : (kind == 2) ? int'($urandom % 64) : int'($urandom % 65536);
      layer(int'($urandom_range(1, 40)), int'($urandom_range(1, 10)), int'($urandom_range(1, 10)),
            off, int'($urandom % 2), int'($urandom_range(30, 100)), 1 << 30);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
